// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the N-to-1 AXI4-Stream byte buses and grant status around uart_tx_arbiter.
// The slave modport is the arbiter's view; master is the environment driving the sources.
interface uart_tx_arbiter_if #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8
);
  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [PORTS-1:0]            s_axis_tvalid;
  logic [PORTS-1:0]            s_axis_tlast;
  logic [PORTS-1:0]            s_axis_tready;
  logic [DATA_WIDTH-1:0]       m_axis_tdata;
  logic                        m_axis_tvalid;
  logic                        m_axis_tready;
  logic [$clog2(PORTS)-1:0]    grant_index;
  logic                        grant_valid;
  logic                        timeout_pulse;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid,
    output grant_index, grant_valid, timeout_pulse
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid,
    input  grant_index, grant_valid, timeout_pulse
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart_tx among PORTS byte streams;
// a grant spans a whole packet and is revoked if the owner stalls for TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_arbiter_if.slave     bus
);
  localparam int              IDX_W      = $clog2(PORTS);
  localparam logic [15:0]     TIMEOUT_W  = 16'(TIMEOUT);
  localparam bit              TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(PORTS - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        grant_index_q, grant_index_d;
  logic                    grant_valid_q, grant_valid_d;
  logic [15:0]             stall_cnt_q, stall_cnt_d;
  logic                    timeout_pulse_q, timeout_pulse_d;

  logic [IDX_W-1:0]        next_idx_s;
  logic                    next_found_s;
  logic [IDX_W-1:0]        cand_s;
  logic [DATA_WIDTH-1:0]   sel_data_s;
  logic                    cur_valid_s;
  logic                    cur_last_s;
  logic                    granted_s;
  logic                    handshake_s;

  // Round-robin search starting just after the current pointer, current port last.
  always_comb begin
    next_idx_s   = grant_index_q;
    next_found_s = 1'b0;
    cand_s       = grant_index_q;
    for (int k = 1; k <= PORTS; k++) begin
      cand_s = IDX_W'((int'(grant_index_q) + k) % PORTS);
      if (!next_found_s && bus.s_axis_tvalid[cand_s]) begin
        next_found_s = 1'b1;
        next_idx_s   = cand_s;
      end else begin
        next_found_s = next_found_s;
      end
    end
  end

  // Select the owner's data, valid and last.
  always_comb begin
    sel_data_s  = '0;
    cur_valid_s = 1'b0;
    cur_last_s  = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_index_q == IDX_W'(i)) begin
        sel_data_s  = bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        cur_valid_s = bus.s_axis_tvalid[i];
        cur_last_s  = bus.s_axis_tlast[i];
      end else begin
        cur_last_s  = cur_last_s;
      end
    end
  end

  assign granted_s   = (state_q == GRANT);
  assign handshake_s = granted_s & cur_valid_s & bus.m_axis_tready;

  // Zero-latency datapath; everything is forced quiet outside GRANT.
  always_comb begin
    bus.s_axis_tready = '0;
    if (granted_s) begin
      bus.m_axis_tdata  = sel_data_s;
      bus.m_axis_tvalid = cur_valid_s;
      for (int i = 0; i < PORTS; i++) begin
        bus.s_axis_tready[i] = (grant_index_q == IDX_W'(i)) & bus.m_axis_tready;
      end
    end else begin
      bus.m_axis_tdata  = '0;
      bus.m_axis_tvalid = 1'b0;
    end
  end

  // Next-state logic for grant, pointer and stall watchdog.
  always_comb begin
    state_d         = state_q;
    grant_index_d   = grant_index_q;
    grant_valid_d   = grant_valid_q;
    stall_cnt_d     = stall_cnt_q;
    timeout_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        stall_cnt_d = 16'd0;
        if (next_found_s) begin
          state_d       = GRANT;
          grant_index_d = next_idx_s;
          grant_valid_d = 1'b1;
        end else begin
          grant_valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (handshake_s) begin
          stall_cnt_d = 16'd0;
          if (cur_last_s) begin
            state_d       = IDLE;
            grant_valid_d = 1'b0;
          end else begin
            grant_valid_d = 1'b1;
          end
        end else if (!cur_valid_s) begin
          // The TIMEOUT-th consecutive stalled cycle revokes at its closing edge.
          if (TIMEOUT_EN && (stall_cnt_q >= TIMEOUT_W - 16'd1)) begin
            state_d         = IDLE;
            grant_valid_d   = 1'b0;
            stall_cnt_d     = 16'd0;
            timeout_pulse_d = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q + 16'd1;
          end
        end else begin
          stall_cnt_d = stall_cnt_q;
        end
      end
      default: begin
        state_d       = IDLE;
        grant_valid_d = 1'b0;
        stall_cnt_d   = 16'd0;
      end
    endcase
  end

  // State registers; reset points at the last port so port 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      grant_index_q   <= LAST_PORT;
      grant_valid_q   <= 1'b0;
      stall_cnt_q     <= 16'd0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_index_q   <= grant_index_d;
      grant_valid_q   <= grant_valid_d;
      stall_cnt_q     <= stall_cnt_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  assign bus.grant_index   = grant_index_q;
  assign bus.grant_valid   = grant_valid_q;
  assign bus.timeout_pulse = timeout_pulse_q;

endmodule
